// File: rtl/halfadd_selftest.sv
// Built-in self-test for a half adder: sweeps all {a,b} vectors for N_ROUNDS rounds,
// checks {carry,sum} against a golden model and reports pass, error count and first failure.
module halfadd_selftest #(
  parameter int N_ROUNDS = 4,
  parameter int WAIT_CYC = 1,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_sum,
  input  logic             dut_carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [1:0]       fail_vec,
  output logic [1:0]       vec_idx
);

  localparam int RND_W = $clog2(N_ROUNDS) + 1;
  localparam int WT_W  = $clog2(WAIT_CYC + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_WAIT, S_CHECK, S_DONE
  } state_t;

  state_t             state_q;
  logic [1:0]         vec_q;
  logic [RND_W-1:0]   round_q;
  logic [WT_W-1:0]    wait_q;
  logic [ERR_W-1:0]   err_q;
  logic [ERR_W-1:0]   err_d;
  logic               busy_q, done_q, pass_q, fail_valid_q;
  logic [1:0]         fail_vec_q;
  logic               dut_a_q, dut_b_q;
  logic               mismatch;
  logic               last_vec;

  function automatic logic [1:0] golden(input logic [1:0] v);
    return {v[1] & v[0], v[1] ^ v[0]};
  endfunction

  // The counter sticks at all-ones so a heavily failing part never wraps back to "pass".
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    mismatch = ({dut_carry, dut_sum} != golden(vec_q));
    err_d    = mismatch ? sat_inc(err_q) : err_q;
    last_vec = (vec_q == 2'd3) && (round_q == RND_W'(N_ROUNDS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      vec_q        <= '0;
      round_q      <= '0;
      wait_q       <= '0;
      err_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      dut_a_q      <= 1'b0;
      dut_b_q      <= 1'b0;
    end else if (ena) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q      <= S_DRIVE;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
            vec_q        <= '0;
            round_q      <= '0;
            wait_q       <= '0;
          end
        end
        S_DRIVE: begin
          dut_a_q <= vec_q[1];
          dut_b_q <= vec_q[0];
          state_q <= (WAIT_CYC > 0) ? S_WAIT : S_CHECK;
        end
        S_WAIT: begin
          if (wait_q == WT_W'(WAIT_CYC - 1)) begin
            wait_q  <= '0;
            state_q <= S_CHECK;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_CHECK: begin
          err_q <= err_d;
          if (mismatch && !fail_valid_q) begin
            fail_valid_q <= 1'b1;
            fail_vec_q   <= vec_q;
          end
          if (last_vec) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            vec_q   <= vec_q + 2'd1;
            if (vec_q == 2'd3) round_q <= round_q + 1'b1;
            state_q <= S_DRIVE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dut_a      = dut_a_q;
  assign dut_b      = dut_b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;
  assign vec_idx    = vec_q;

endmodule

// File: tb/tb_halfadd_selftest.sv
// Bench for halfadd_selftest: a fault-injectable half adder feeds two instances
// (8-bit and 2-bit error counters); expected run outcomes are queued at start and checked at done.
module tb_halfadd_selftest;

  localparam int NR = 2;
  localparam int WC = 1;
  localparam int BASE_LAT = 4 * NR * (2 + WC);

  logic clk = 1'b0;
  logic rst_n, ena, start;
  logic [1:0] fault;

  logic dut_a, dut_b, dut_sum, dut_carry;
  logic busy, done, pass, fail_valid;
  logic [7:0] err_cnt;
  logic [1:0] fail_vec, vec_idx;

  logic dut_a2, dut_b2, dut_sum2, dut_carry2;
  logic busy2, done2, pass2, fail_valid2;
  logic [1:0] err_cnt2;
  logic [1:0] fail_vec2, vec_idx2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int lat;
    int pass;
    int err;
    int fv;
    int fvec;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // fault 0: correct adder, 1: carry stuck at 0, 2: inverted sum
  always_comb begin
    dut_sum    = (dut_a ^ dut_b) ^ (fault == 2'd2);
    dut_carry  = (fault == 2'd1) ? 1'b0 : (dut_a & dut_b);
    dut_sum2   = (dut_a2 ^ dut_b2) ^ (fault == 2'd2);
    dut_carry2 = (fault == 2'd1) ? 1'b0 : (dut_a2 & dut_b2);
  end

  halfadd_selftest #(.N_ROUNDS(NR), .WAIT_CYC(WC), .ERR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .dut_a(dut_a), .dut_b(dut_b), .dut_sum(dut_sum), .dut_carry(dut_carry),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_valid(fail_valid), .fail_vec(fail_vec), .vec_idx(vec_idx)
  );

  halfadd_selftest #(.N_ROUNDS(NR), .WAIT_CYC(WC), .ERR_W(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .dut_a(dut_a2), .dut_b(dut_b2), .dut_sum(dut_sum2), .dut_carry(dut_carry2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
    .fail_valid(fail_valid2), .fail_vec(fail_vec2), .vec_idx(vec_idx2)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int f, input bit frz);
    exp_t e;
    bit a, b;
    int gs, gc;
    e.lat  = BASE_LAT + (frz ? 5 : 0);
    e.err  = 0;
    e.fv   = 0;
    e.fvec = 0;
    for (int r = 0; r < NR; r++) begin
      for (int v = 0; v < 4; v++) begin
        a  = v[1];
        b  = v[0];
        gs = (a ^ b) ^ (f == 2);
        gc = (f == 1) ? 0 : (a & b);
        if (gs != (a ^ b) || gc != (a & b)) begin
          e.err++;
          if (e.fv == 0) begin
            e.fv   = 1;
            e.fvec = v;
          end
        end
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input int f, input bit frz, input bit rep, input string nm);
    exp_t e;
    int cyc, en_e;
    bit en_at;
    fault = 2'(f);
    sb.push_back(model(f, frz));
    pulse_start();
    cyc  = 0;
    en_e = 0;
    chk({nm, "_clr_done"}, done, 0);
    chk({nm, "_clr_err"}, err_cnt, 0);
    chk({nm, "_clr_fv"}, fail_valid, 0);
    chk({nm, "_busy"}, busy, 1);
    while (!done && cyc < 100) begin
      chk({nm, "_vec_idx"}, vec_idx, (en_e / 3) % 4);
      if (frz && cyc == 6)  ena = 1'b0;
      if (frz && cyc == 11) ena = 1'b1;
      if (rep && cyc == 10) start = 1'b1;
      if (rep && cyc == 11) start = 1'b0;
      en_at = ena;
      @(negedge clk);
      cyc++;
      if (en_at) en_e++;
    end
    e = sb.pop_front();
    chk({nm, "_latency"}, cyc, e.lat);
    chk({nm, "_done"}, done, 1);
    chk({nm, "_busy_end"}, busy, 0);
    chk({nm, "_pass"}, pass, e.pass);
    chk({nm, "_err_cnt"}, err_cnt, e.err);
    chk({nm, "_fail_valid"}, fail_valid, e.fv);
    chk({nm, "_fail_vec"}, fail_vec, e.fvec);
    chk({nm, "_vec_end"}, vec_idx, 3);
    chk({nm, "_sat_done"}, done2, 1);
    chk({nm, "_sat_busy"}, busy2, 0);
    chk({nm, "_sat_err"}, err_cnt2, (e.err > 3) ? 3 : e.err);
    chk({nm, "_sat_pass"}, pass2, e.pass);
    chk({nm, "_sat_fv"}, fail_valid2, e.fv);
    chk({nm, "_sat_fvec"}, fail_vec2, e.fvec);
    chk({nm, "_sat_vec"}, vec_idx2, 3);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_pass"}, pass, 0);
    chk({nm, "_err"}, err_cnt, 0);
    chk({nm, "_fv"}, fail_valid, 0);
    chk({nm, "_fvec"}, fail_vec, 0);
    chk({nm, "_vec"}, vec_idx, 0);
    chk({nm, "_a"}, dut_a, 0);
    chk({nm, "_b"}, dut_b, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    ena   = 1'b1;
    start = 1'b0;
    fault = 2'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 1'b0, 1'b0, "good");
    run(1, 1'b0, 1'b0, "carry_sa0");
    run(2, 1'b0, 1'b0, "inv_sum");
    run(0, 1'b0, 1'b0, "after_fail");
    run(0, 1'b1, 1'b0, "freeze");
    run(0, 1'b0, 1'b1, "restart");

    // Abort in WAIT of vector 2, after two sum mismatches have been counted.
    fault = 2'd2;
    pulse_start();
    repeat (7) @(negedge clk);
    chk("pre_abort_err", err_cnt, 2);
    chk("pre_abort_vec", vec_idx, 2);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(0, 1'b0, 1'b0, "post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
